// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single data-memory bus between store-buffer load/drain and instruction fetch.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int SIZE_W       = 2,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] stbuf_bus_read_addr,
  input  logic [SIZE_W-1:0] stbuf_bus_read_size,
  input  logic              stbuf_bus_read_req,
  input  logic [ADDR_W-1:0] stbuf_bus_write_addr,
  input  logic [SIZE_W-1:0] stbuf_bus_write_size,
  input  logic [DATA_W-1:0] stbuf_bus_data,
  input  logic              stbuf_bus_write_req,
  output logic [DATA_W-1:0] bus_stbuf_data,
  output logic              bus_stbuf_read_ack,
  output logic              bus_stbuf_write_ack,
  input  logic [ADDR_W-1:0] fetch_bus_read_addr,
  input  logic              fetch_bus_read_req,
  output logic [DATA_W-1:0] bus_fetch_data,
  output logic              bus_fetch_read_ack,
  output logic [ADDR_W-1:0] arb_bus_addr,
  output logic [SIZE_W-1:0] arb_bus_size,
  output logic [DATA_W-1:0] arb_bus_wdata,
  output logic              arb_bus_read_req,
  output logic              arb_bus_write_req,
  input  logic [DATA_W-1:0] bus_arb_rdata,
  input  logic              bus_arb_ack
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OWN_SR = 3'd1,
    OWN_SW = 3'd2,
    OWN_F  = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t state_r;
  state_t state_n_s;
  logic   starve_hit_s;

  assign bus_stbuf_data      = bus_arb_rdata;
  assign bus_fetch_data      = bus_arb_rdata;
  assign bus_stbuf_read_ack  = (state_r == OWN_SR) && bus_arb_ack;
  assign bus_stbuf_write_ack = (state_r == OWN_SW) && bus_arb_ack;
  assign bus_fetch_read_ack  = (state_r == OWN_F)  && bus_arb_ack;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt_r;

  assign starve_hit_s = (starve_cnt_r == CNT_W'(STARVE_LIMIT));

  // Counts cycles a live fetch request waits without owning the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (!fetch_bus_read_req) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == IDLE) && (state_n_s == OWN_F)) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r != OWN_F) && !starve_hit_s) begin
      starve_cnt_r <= starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`else
  assign starve_hit_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Next-state: grant in IDLE, release on ack, divert to DRAIN when the owner withdraws.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (starve_hit_s && fetch_bus_read_req) state_n_s = OWN_F;
        else if (stbuf_bus_read_req)            state_n_s = OWN_SR;
        else if (stbuf_bus_write_req)           state_n_s = OWN_SW;
        else if (fetch_bus_read_req)            state_n_s = OWN_F;
        else                                    state_n_s = IDLE;
      end
      OWN_SR: begin
        if (bus_arb_ack)              state_n_s = IDLE;
        else if (!stbuf_bus_read_req) state_n_s = DRAIN;
        else                          state_n_s = OWN_SR;
      end
      OWN_SW: begin
        if (bus_arb_ack)               state_n_s = IDLE;
        else if (!stbuf_bus_write_req) state_n_s = DRAIN;
        else                           state_n_s = OWN_SW;
      end
      OWN_F: begin
        if (bus_arb_ack)              state_n_s = IDLE;
        else if (!fetch_bus_read_req) state_n_s = DRAIN;
        else                          state_n_s = OWN_F;
      end
      DRAIN: begin
        if (bus_arb_ack) state_n_s = IDLE;
        else             state_n_s = DRAIN;
      end
      default: state_n_s = IDLE;
    endcase
  end

  // Bus request fields: latched on grant, frozen while owned, cleared on return to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arb_bus_addr      <= {ADDR_W{1'b0}};
      arb_bus_size      <= {SIZE_W{1'b0}};
      arb_bus_wdata     <= {DATA_W{1'b0}};
      arb_bus_read_req  <= 1'b0;
      arb_bus_write_req <= 1'b0;
    end else if (state_r == IDLE) begin
      case (state_n_s)
        OWN_SR: begin
          arb_bus_addr      <= stbuf_bus_read_addr;
          arb_bus_size      <= stbuf_bus_read_size;
          arb_bus_wdata     <= {DATA_W{1'b0}};
          arb_bus_read_req  <= 1'b1;
          arb_bus_write_req <= 1'b0;
        end
        OWN_SW: begin
          arb_bus_addr      <= stbuf_bus_write_addr;
          arb_bus_size      <= stbuf_bus_write_size;
          arb_bus_wdata     <= stbuf_bus_data;
          arb_bus_read_req  <= 1'b0;
          arb_bus_write_req <= 1'b1;
        end
        OWN_F: begin
          arb_bus_addr      <= fetch_bus_read_addr;
          arb_bus_size      <= SIZE_W'(2'b10);
          arb_bus_wdata     <= {DATA_W{1'b0}};
          arb_bus_read_req  <= 1'b1;
          arb_bus_write_req <= 1'b0;
        end
        default: begin
          arb_bus_addr      <= {ADDR_W{1'b0}};
          arb_bus_size      <= {SIZE_W{1'b0}};
          arb_bus_wdata     <= {DATA_W{1'b0}};
          arb_bus_read_req  <= 1'b0;
          arb_bus_write_req <= 1'b0;
        end
      endcase
    end else if (state_n_s == IDLE) begin
      arb_bus_addr      <= {ADDR_W{1'b0}};
      arb_bus_size      <= {SIZE_W{1'b0}};
      arb_bus_wdata     <= {DATA_W{1'b0}};
      arb_bus_read_req  <= 1'b0;
      arb_bus_write_req <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: per-cycle vector table plus hand sequences
// for reset mid-transaction and fetch starvation (behaviour depends on ARB_STARVE_GUARD_EN).
module tb_mem_bus_arbiter;

  localparam logic [31:0] RD_ADDR = 32'h1524abe0;
  localparam logic [1:0]  RD_SIZE = 2'b01;
  localparam logic [31:0] WR_ADDR = 32'h00001000;
  localparam logic [1:0]  WR_SIZE = 2'b10;
  localparam logic [31:0] WR_DATA = 32'hcafef00d;
  localparam logic [31:0] F_ADDR  = 32'h80000000;

  logic        clk;
  logic        rst;
  logic [31:0] stbuf_bus_read_addr;
  logic [1:0]  stbuf_bus_read_size;
  logic        stbuf_bus_read_req;
  logic [31:0] stbuf_bus_write_addr;
  logic [1:0]  stbuf_bus_write_size;
  logic [31:0] stbuf_bus_data;
  logic        stbuf_bus_write_req;
  logic [31:0] bus_stbuf_data;
  logic        bus_stbuf_read_ack;
  logic        bus_stbuf_write_ack;
  logic [31:0] fetch_bus_read_addr;
  logic        fetch_bus_read_req;
  logic [31:0] bus_fetch_data;
  logic        bus_fetch_read_ack;
  logic [31:0] arb_bus_addr;
  logic [1:0]  arb_bus_size;
  logic [31:0] arb_bus_wdata;
  logic        arb_bus_read_req;
  logic        arb_bus_write_req;
  logic [31:0] bus_arb_rdata;
  logic        bus_arb_ack;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter dut (
    .clk                  (clk),
    .rst                  (rst),
    .stbuf_bus_read_addr  (stbuf_bus_read_addr),
    .stbuf_bus_read_size  (stbuf_bus_read_size),
    .stbuf_bus_read_req   (stbuf_bus_read_req),
    .stbuf_bus_write_addr (stbuf_bus_write_addr),
    .stbuf_bus_write_size (stbuf_bus_write_size),
    .stbuf_bus_data       (stbuf_bus_data),
    .stbuf_bus_write_req  (stbuf_bus_write_req),
    .bus_stbuf_data       (bus_stbuf_data),
    .bus_stbuf_read_ack   (bus_stbuf_read_ack),
    .bus_stbuf_write_ack  (bus_stbuf_write_ack),
    .fetch_bus_read_addr  (fetch_bus_read_addr),
    .fetch_bus_read_req   (fetch_bus_read_req),
    .bus_fetch_data       (bus_fetch_data),
    .bus_fetch_read_ack   (bus_fetch_read_ack),
    .arb_bus_addr         (arb_bus_addr),
    .arb_bus_size         (arb_bus_size),
    .arb_bus_wdata        (arb_bus_wdata),
    .arb_bus_read_req     (arb_bus_read_req),
    .arb_bus_write_req    (arb_bus_write_req),
    .bus_arb_rdata        (bus_arb_rdata),
    .bus_arb_ack          (bus_arb_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus and the outputs expected while it is applied.
  // sel: which requester's fields must be on the bus (0 none, 1 stbuf read, 2 stbuf write, 3 fetch).
  typedef struct {
    logic       rd;
    logic       wr;
    logic       f;
    logic       ack;
    logic [1:0] sel;
    logic       a_sr;
    logic       a_sw;
    logic       a_f;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rd, logic wr, logic f, logic ack, logic [1:0] sel,
                              logic a_sr, logic a_sw, logic a_f);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f = f; v.ack = ack; v.sel = sel;
    v.a_sr = a_sr; v.a_sw = a_sw; v.a_f = a_f;
    return v;
  endfunction

  function automatic logic [70:0] observed();
    return {arb_bus_read_req, arb_bus_write_req, arb_bus_addr, arb_bus_size, arb_bus_wdata,
            bus_stbuf_read_ack, bus_stbuf_write_ack, bus_fetch_read_ack};
  endfunction

  function automatic logic [70:0] expect_out(logic [1:0] sel, logic a_sr, logic a_sw, logic a_f);
    logic [31:0] a;
    logic [1:0]  s;
    logic [31:0] d;
    logic        r;
    logic        w;
    case (sel)
      2'd1:    begin a = RD_ADDR; s = RD_SIZE; d = 32'h0;   r = 1'b1; w = 1'b0; end
      2'd2:    begin a = WR_ADDR; s = WR_SIZE; d = WR_DATA; r = 1'b0; w = 1'b1; end
      2'd3:    begin a = F_ADDR;  s = 2'b10;   d = 32'h0;   r = 1'b1; w = 1'b0; end
      default: begin a = 32'h0;   s = 2'b00;   d = 32'h0;   r = 1'b0; w = 1'b0; end
    endcase
    return {r, w, a, s, d, a_sr, a_sw, a_f};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int grant_k;
    rst = 1'b0;
    stbuf_bus_read_addr  = RD_ADDR;
    stbuf_bus_read_size  = RD_SIZE;
    stbuf_bus_read_req   = 1'b0;
    stbuf_bus_write_addr = WR_ADDR;
    stbuf_bus_write_size = WR_SIZE;
    stbuf_bus_data       = WR_DATA;
    stbuf_bus_write_req  = 1'b0;
    fetch_bus_read_addr  = F_ADDR;
    fetch_bus_read_req   = 1'b0;
    bus_arb_rdata        = 32'h0;
    bus_arb_ack          = 1'b0;

    //            rd   wr   f    ack  sel  a_sr a_sw a_f
    // reset release, idle, stray ack ignored
    vq.push_back(mk(1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b0,1'b0,1'b0,1'b1,2'd0,1'b0,1'b0,1'b0));
    // single stbuf read, ack two cycles after grant
    vq.push_back(mk(1'b1,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b1,1'b0,1'b0,1'b0,2'd1,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b1,1'b0,1'b0,1'b0,2'd1,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b1,1'b0,1'b0,1'b1,2'd1,1'b1,1'b0,1'b0));
    vq.push_back(mk(1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0));
    // all three together: read, then write, then fetch, idle cycle between each
    vq.push_back(mk(1'b1,1'b1,1'b1,1'b0,2'd0,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b1,1'b1,1'b1,1'b0,2'd1,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b1,1'b1,1'b1,1'b1,2'd1,1'b1,1'b0,1'b0));
    vq.push_back(mk(1'b0,1'b1,1'b1,1'b0,2'd0,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b0,1'b1,1'b1,1'b1,2'd2,1'b0,1'b1,1'b0));
    vq.push_back(mk(1'b0,1'b0,1'b1,1'b0,2'd0,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b0,1'b0,1'b1,1'b1,2'd3,1'b0,1'b0,1'b1));
    vq.push_back(mk(1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0));
    // fetch flushed before ack: drain, no ack forwarded, then a read follows
    vq.push_back(mk(1'b0,1'b0,1'b1,1'b0,2'd0,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b0,1'b0,1'b1,1'b0,2'd3,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b0,1'b0,1'b0,1'b0,2'd3,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b0,1'b0,1'b0,1'b0,2'd3,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b1,1'b0,1'b0,1'b1,2'd3,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b1,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b1,1'b0,1'b0,1'b1,2'd1,1'b1,1'b0,1'b0));
    vq.push_back(mk(1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0));
    // fetch drop and ack in the same cycle: ack forwarded, straight to IDLE
    vq.push_back(mk(1'b0,1'b0,1'b1,1'b0,2'd0,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b0,1'b0,1'b1,1'b0,2'd3,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b0,1'b0,1'b0,1'b1,2'd3,1'b0,1'b0,1'b1));
    vq.push_back(mk(1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0));

    #1;
    chk("reset_outputs", 128'(observed()), 128'(expect_out(2'd0, 1'b0, 1'b0, 1'b0)));
    #11;
    rst = 1'b1;
    next_cycle();

    for (int i = 0; i < vq.size(); i++) begin
      stbuf_bus_read_req  = vq[i].rd;
      stbuf_bus_write_req = vq[i].wr;
      fetch_bus_read_req  = vq[i].f;
      bus_arb_ack         = vq[i].ack;
      bus_arb_rdata       = 32'hdead0000 + 32'(i);
      #1;
      chk($sformatf("vec%0d", i), 128'(observed()),
          128'(expect_out(vq[i].sel, vq[i].a_sr, vq[i].a_sw, vq[i].a_f)));
      chk($sformatf("rdata%0d", i), 128'({bus_stbuf_data, bus_fetch_data}),
          128'({32'hdead0000 + 32'(i), 32'hdead0000 + 32'(i)}));
      next_cycle();
    end
    stbuf_bus_read_req = 1'b0; stbuf_bus_write_req = 1'b0;
    fetch_bus_read_req = 1'b0; bus_arb_ack = 1'b0;

    // reset while a write owns the bus, then re-grant of the still-held write
    stbuf_bus_write_req = 1'b1;
    next_cycle();
    #1;
    chk("sw_grant", 128'(observed()), 128'(expect_out(2'd2, 1'b0, 1'b0, 1'b0)));
    stbuf_bus_write_addr = 32'h0000beef;
    stbuf_bus_data       = 32'h12345678;
    next_cycle();
    #1;
    chk("sw_latched", 128'(observed()), 128'(expect_out(2'd2, 1'b0, 1'b0, 1'b0)));
    stbuf_bus_write_addr = WR_ADDR;
    stbuf_bus_data       = WR_DATA;
    bus_arb_ack = 1'b1;
    rst = 1'b0;
    #1;
    chk("sw_reset", 128'(observed()), 128'(expect_out(2'd0, 1'b0, 1'b0, 1'b0)));
    next_cycle();
    bus_arb_ack = 1'b0;
    rst = 1'b1;
    #1;
    chk("sw_after_rst", 128'(observed()), 128'(expect_out(2'd0, 1'b0, 1'b0, 1'b0)));
    next_cycle();
    #1;
    chk("sw_regrant", 128'(observed()), 128'(expect_out(2'd2, 1'b0, 1'b0, 1'b0)));
    bus_arb_ack = 1'b1;
    #1;
    chk("sw_ack", 128'(observed()), 128'(expect_out(2'd2, 1'b0, 1'b1, 1'b0)));
    next_cycle();
    stbuf_bus_write_req = 1'b0;
    bus_arb_ack = 1'b0;
    next_cycle();

    // fetch held against a continuously re-granted stbuf write
    grant_k = -1;
    stbuf_bus_write_req = 1'b1;
    fetch_bus_read_req  = 1'b1;
    bus_arb_ack         = 1'b1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (grant_k < 0 && arb_bus_read_req && arb_bus_addr == F_ADDR) grant_k = k;
      next_cycle();
    end
`ifdef ARB_STARVE_GUARD_EN
    chk("starve_grant_cycle", 128'(grant_k), 128'(9));
`else
    chk("starve_never_granted", 128'(grant_k), 128'(-1));
`endif
    stbuf_bus_write_req = 1'b0;
    fetch_bus_read_req  = 1'b0;
    bus_arb_ack         = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    chk("final_idle", 128'(observed()), 128'(expect_out(2'd0, 1'b0, 1'b0, 1'b0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
